led_matrix_scan: RTL and testbench
==================================

LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter ROWS, default 9, number of matrix rows scanned (2..16).
REQ-002 SHALL have parameter COLS, default 8, number of column lines (1..16).
REQ-003 SHALL have parameter PERIOD, default 27000, sys_clk cycles per row slot.
REQ-004 SHALL have parameter GAP_ON, default 100, blank cycles at the start of each row slot.
REQ-005 SHALL have parameter GAP_OFF, default 2000, blank cycles at the end of each row slot.
REQ-006 SHALL have parameter BRIGHT_W, default 4, brightness field width.
REQ-007 SHALL have port sys_clk  input  1  the only clock; all state on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port wr  input  1  back-buffer write strobe.
REQ-010 SHALL have port wr_row  input  4  target row of the write.
REQ-011 SHALL have port wr_data  input  COLS  row pattern to write, 1 = LED lit.
REQ-012 SHALL have port bright  input  BRIGHT_W  global brightness level.
REQ-013 SHALL have port swap_req  input  1  request a back-to-front frame copy.
REQ-014 SHALL have port swap_ack  output  1  one-cycle pulse when the copy has occurred.
REQ-015 SHALL have port led_row  output  ROWS  active-low row drive.
REQ-016 SHALL have port led_col  output  COLS  active-high column pattern.
REQ-017 SHALL have port row_index  output  4  currently scanned row.

Function
REQ-018 SHALL hold two frame buffers, front and back, each ROWS x COLS bits.
REQ-019 SHALL write wr_data into back[wr_row] on an edge with wr=1; writes with wr_row>=ROWS SHALL be ignored, and front SHALL never be written directly.
REQ-020 SHALL count counter 0..PERIOD-1 and wrap to 0; on the edge where counter wraps, row_index SHALL advance, and ROWS-1 SHALL advance to 0.
REQ-021 SHALL latch bright into bright_q on every row advance; bright changes mid-slot SHALL NOT affect the current slot.
REQ-022 SHALL run a free-running BRIGHT_W-bit pwm counter, incrementing every cycle and wrapping.
REQ-023 SHALL define lit = (GAP_ON <= counter < PERIOD-GAP_OFF) AND (bright_q == all-ones OR pwm < bright_q).
REQ-024 SHALL drive led_row = all-ones XOR (lit << row_index), so at most one bit is low.
REQ-025 SHALL drive led_col = front[row_index] regardless of lit.
REQ-026 SHALL derive outputs only from registered state, with no combinational path from inputs.
REQ-027 SHALL set pending on swap_req=1; a swap_req while already pending SHALL have no further effect.
REQ-028 SHALL, at the frame-end edge (row_index==ROWS-1, counter==PERIOD-1), copy all of back into front when pending, or when swap_req=1 in that same cycle; pending SHALL clear, and swap_ack SHALL be 1 for exactly the following cycle.
REQ-029 SHALL, when wr coincides with the frame-end copy edge, copy the pre-write back value into front; the write lands in back only and reaches front at the next swap.
REQ-030 SHALL hold swap_ack at 0 when no swap occurs.
REQ-031 SHALL treat bright_q=0 as fully dark: led_row all-ones for the whole slot.

Reset
REQ-032 SHALL, on rst_n low and asynchronously, clear counter, row_index, pwm, bright_q, pending, swap_ack, and both buffers to 0.
REQ-033 SHALL hold led_row at all-ones and led_col at 0 while rst_n is low.
REQ-034 SHALL discard any pending swap when reset is asserted mid-frame.
REQ-035 SHALL start the first row slot at row 0, counter 0, after rst_n deasserts.

Verification
REQ-036 SHALL verify scan timing: with PERIOD=20, GAP_ON=2, GAP_OFF=3, ROWS=3, bright=all-ones, led_row bit r SHALL be low for counter 2..16 of slot r, and row_index SHALL go 0,1,2,0.
REQ-037 SHALL verify buffer isolation: write back[1]=0xA5 without swap_req, then front[1] and led_col during row 1 SHALL remain 0x00.
REQ-038 SHALL verify swap: write back[1]=0xA5, pulse swap_req mid-frame, then swap_ack SHALL pulse once one cycle after frame end, and the next row-1 slot SHALL show led_col=0xA5.
REQ-039 SHALL verify a write coincident with swap: wr back[0]=0x3C on the frame-end edge with pending set, then front[0] SHALL get the old value and 0x3C SHALL appear only after a second swap.
REQ-040 SHALL verify PWM: with BRIGHT_W=4 and bright=4, over 16 consecutive in-window cycles lit SHALL be asserted exactly 4 times; with bright=0, zero times.
REQ-041 SHALL verify reset: assert rst_n low mid-slot with swap pending, then outputs SHALL immediately read led_row all-ones and led_col=0, and no swap_ack SHALL occur after release.

Source files
------------

// File: rtl/led_matrix_scan.sv
// LED matrix row scanner with double-buffered frame memory,
// gap blanking, PWM dimming and frame-synchronous buffer swap.
module led_matrix_scan #(
   parameter int ROWS     = 9,
   parameter int COLS     = 8,
   parameter int PERIOD   = 27000,
   parameter int GAP_ON   = 100,
   parameter int GAP_OFF  = 2000,
   parameter int BRIGHT_W = 4
) (
   input  logic                sys_clk,
   input  logic                rst_n,
   input  logic                wr,
   input  logic [3:0]          wr_row,
   input  logic [COLS-1:0]     wr_data,
   input  logic [BRIGHT_W-1:0] bright,
   input  logic                swap_req,
   output logic                swap_ack,
   output logic [ROWS-1:0]     led_row,
   output logic [COLS-1:0]     led_col,
   output logic [3:0]          row_index
);

   localparam int CW = $clog2(PERIOD + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] WIN_LO = CW'(GAP_ON);
   localparam logic [CW-1:0] WIN_HI = CW'(PERIOD - GAP_OFF);
   localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
   localparam logic [BRIGHT_W-1:0] B_FULL = '1;

   logic [CW-1:0]       counter_q, counter_d;
   logic [3:0]          row_q, row_d;
   logic [BRIGHT_W-1:0] pwm_q, pwm_d;
   logic [BRIGHT_W-1:0] bright_q, bright_d;
   logic                pending_q, pending_d;
   logic                swap_ack_q, swap_ack_d;
   logic [COLS-1:0]     front_q [ROWS];
   logic [COLS-1:0]     front_d [ROWS];
   logic [COLS-1:0]     back_q [ROWS];
   logic [COLS-1:0]     back_d [ROWS];

   logic wrap;
   logic frame_end;
   logic do_swap;
   logic in_win;
   logic pwm_on;
   logic lit;

   // Slot timer, row sequencer, PWM counter and per-slot brightness latch
   always_comb begin
      wrap      = (counter_q == CNT_LAST);
      counter_d = counter_q + CW'(1);
      row_d     = row_q;
      bright_d  = bright_q;
      pwm_d     = pwm_q + BRIGHT_W'(1);
      if (wrap) begin
         counter_d = '0;
         bright_d  = bright;
         if (row_q == ROW_LAST) begin
            row_d = '0;
         end else begin
            row_d = row_q + 4'd1;
         end
      end
   end

   // Swap request tracking; copy happens only on the last edge of a frame
   always_comb begin
      frame_end  = wrap && (row_q == ROW_LAST);
      do_swap    = frame_end && (pending_q || swap_req);
      pending_d  = pending_q;
      swap_ack_d = do_swap;
      if (do_swap) begin
         pending_d = 1'b0;
      end else if (swap_req) begin
         pending_d = 1'b1;
      end
   end

   // Back buffer takes writes; front only loads from the pre-write back
   always_comb begin
      front_d = front_q;
      back_d  = back_q;
      for (int r = 0; r < ROWS; r++) begin
         if (do_swap) begin
            front_d[r] = back_q[r];
         end
         if (wr && (wr_row == 4'(r))) begin
            back_d[r] = wr_data;
         end
      end
   end

   // Output drive decoded purely from registered state
   always_comb begin
      in_win  = (counter_q >= WIN_LO) && (counter_q < WIN_HI);
      pwm_on  = (bright_q == B_FULL) || (pwm_q < bright_q);
      lit     = in_win && pwm_on;
      led_row = ~(ROWS'(lit) << row_q);
      led_col = '0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_q == 4'(r)) begin
            led_col = front_q[r];
         end
      end
   end

   assign row_index = row_q;
   assign swap_ack  = swap_ack_q;

   // State registers, all cleared asynchronously
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q  <= '0;
         row_q      <= '0;
         pwm_q      <= '0;
         bright_q   <= '0;
         pending_q  <= 1'b0;
         swap_ack_q <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            front_q[r] <= '0;
            back_q[r]  <= '0;
         end
      end else begin
         counter_q  <= counter_d;
         row_q      <= row_d;
         pwm_q      <= pwm_d;
         bright_q   <= bright_d;
         pending_q  <= pending_d;
         swap_ack_q <= swap_ack_d;
         for (int r = 0; r < ROWS; r++) begin
            front_q[r] <= front_d[r];
            back_q[r]  <= back_d[r];
         end
      end
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: expectations queued by
// stimulus, compared by a negedge monitor at their cycle.
module tb_led_matrix_scan;

   localparam int ROWS = 3;
   localparam int COLS = 8;
   localparam int PERIOD = 20;
   localparam int GAP_ON = 2;
   localparam int GAP_OFF = 3;
   localparam int BW = 4;

   logic            sys_clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            wr = 1'b0;
   logic [3:0]      wr_row = '0;
   logic [COLS-1:0] wr_data = '0;
   logic [BW-1:0]   bright = 4'hF;
   logic            swap_req = 1'b0;
   logic            swap_ack;
   logic [ROWS-1:0] led_row;
   logic [COLS-1:0] led_col;
   logic [3:0]      row_index;

   led_matrix_scan #(
      .ROWS(ROWS), .COLS(COLS), .PERIOD(PERIOD),
      .GAP_ON(GAP_ON), .GAP_OFF(GAP_OFF), .BRIGHT_W(BW)
   ) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .wr(wr),
      .wr_row(wr_row), .wr_data(wr_data), .bright(bright),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .led_row(led_row), .led_col(led_col),
      .row_index(row_index)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      int              c;
      logic [ROWS-1:0] row;
      logic [COLS-1:0] col;
      logic [3:0]      ri;
      logic            ack;
      string           name;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int cyc = 0;
   int base = 0;
   int n_chk = 0;
   int n_fail = 0;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic exp_at(input int rel, input logic [ROWS-1:0] row,
                         input logic [COLS-1:0] col, input logic [3:0] ri,
                         input logic ack, input string nm);
      exp_t e;
      e.c = base + rel;
      e.row = row;
      e.col = col;
      e.ri = ri;
      e.ack = ack;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic goto(input int rel);
      while (cyc < base + rel) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation
   always @(negedge sys_clk) begin
      while (q.size() > 0 && q[0].c <= cyc) begin
         m = q.pop_front();
         n_chk++;
         if (m.c < cyc) begin
            n_fail++;
            $display("FAIL %s: sample cycle %0d missed (now %0d)",
                     m.name, m.c, cyc);
         end else if (led_row !== m.row || led_col !== m.col ||
                      row_index !== m.ri || swap_ack !== m.ack) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got row=%b col=%h ri=%0d ack=%b, expected row=%b col=%h ri=%0d ack=%b",
                     m.name, cyc, led_row, led_col, row_index, swap_ack,
                     m.row, m.col, m.ri, m.ack);
         end
      end
   end

   initial begin
      exp_at(3, 3'b111, 8'h00, 4'd0, 1'b0, "reset_hold");
      goto(5);
      rst_n = 1'b1;
      base = cyc;

      exp_at(0, 3'b111, 8'h00, 4'd0, 1'b0, "start_row0");
      exp_at(2, 3'b111, 8'h00, 4'd0, 1'b0, "dark_first_slot");
      exp_at(20, 3'b111, 8'h00, 4'd1, 1'b0, "row1_gap_on");
      exp_at(22, 3'b101, 8'h00, 4'd1, 1'b0, "row1_lit_first");
      exp_at(25, 3'b101, 8'h00, 4'd1, 1'b0, "isolation");
      exp_at(36, 3'b101, 8'h00, 4'd1, 1'b0, "row1_lit_last");
      exp_at(37, 3'b111, 8'h00, 4'd1, 1'b0, "row1_gap_off");
      exp_at(42, 3'b011, 8'h00, 4'd2, 1'b0, "row2_lit_first");
      exp_at(56, 3'b011, 8'h00, 4'd2, 1'b0, "row2_lit_last");
      exp_at(57, 3'b111, 8'h00, 4'd2, 1'b0, "row2_gap_off");
      exp_at(59, 3'b111, 8'h00, 4'd2, 1'b0, "frame0_end");
      exp_at(60, 3'b111, 8'h00, 4'd0, 1'b0, "row_wrap");
      exp_at(61, 3'b111, 8'h00, 4'd0, 1'b0, "row0_gap_on");
      exp_at(62, 3'b110, 8'h00, 4'd0, 1'b0, "row0_lit_first");
      exp_at(76, 3'b110, 8'h00, 4'd0, 1'b0, "row0_lit_last");
      exp_at(77, 3'b111, 8'h00, 4'd0, 1'b0, "row0_gap_off");
      exp_at(85, 3'b101, 8'h00, 4'd1, 1'b0, "pending_no_copy");
      exp_at(119, 3'b111, 8'h00, 4'd2, 1'b0, "pre_swap");
      exp_at(120, 3'b111, 8'h00, 4'd0, 1'b1, "swap_ack");
      exp_at(121, 3'b111, 8'h00, 4'd0, 1'b0, "swap_ack_once");
      exp_at(125, 3'b110, 8'h00, 4'd0, 1'b0, "row0_after_swap");
      exp_at(145, 3'b101, 8'hA5, 4'd1, 1'b0, "swapped_row1");
      exp_at(180, 3'b111, 8'h00, 4'd0, 1'b1, "coincident_ack");
      exp_at(185, 3'b110, 8'h00, 4'd0, 1'b0, "coincident_old");
      exp_at(205, 3'b101, 8'hA5, 4'd1, 1'b0, "row1_kept");
      exp_at(240, 3'b111, 8'h3C, 4'd0, 1'b1, "second_swap_ack");
      exp_at(241, 3'b111, 8'h3C, 4'd0, 1'b0, "second_ack_once");
      exp_at(245, 3'b110, 8'h3C, 4'd0, 1'b0, "second_swap_data");
      for (int r = 260; r < 280; r++) begin
         exp_at(r, (r >= 272 && r <= 275) ? 3'b101 : 3'b111,
                8'hA5, 4'd1, 1'b0, "pwm_bright4");
      end
      for (int r = 280; r < 300; r++) begin
         exp_at(r, 3'b111, 8'h00, 4'd2, 1'b0, "pwm_bright0");
      end
      exp_at(300, 3'b111, 8'h3C, 4'd0, 1'b0, "no_swap_no_ack");
      exp_at(325, 3'b101, 8'hA5, 4'd1, 1'b0, "bright_restored");
      exp_at(334, 3'b101, 8'hA5, 4'd1, 1'b0, "pre_reset");
      exp_at(335, 3'b111, 8'h00, 4'd0, 1'b0, "reset_immediate");
      exp_at(338, 3'b111, 8'h00, 4'd0, 1'b0, "reset_held");

      goto(3);
      wr = 1'b1;
      wr_row = 4'd1;
      wr_data = 8'hA5;
      goto(4);
      wr_row = 4'd3;
      wr_data = 8'hFF;
      goto(5);
      wr = 1'b0;

      goto(70);
      swap_req = 1'b1;
      goto(71);
      swap_req = 1'b0;

      goto(130);
      swap_req = 1'b1;
      goto(131);
      swap_req = 1'b0;

      goto(179);
      wr = 1'b1;
      wr_row = 4'd0;
      wr_data = 8'h3C;
      goto(180);
      wr = 1'b0;

      goto(200);
      swap_req = 1'b1;
      goto(201);
      swap_req = 1'b0;

      goto(250);
      bright = 4'd4;
      goto(270);
      bright = 4'd0;
      goto(300);
      bright = 4'hF;

      goto(330);
      swap_req = 1'b1;
      goto(331);
      swap_req = 1'b0;
      goto(335);
      rst_n = 1'b0;
      goto(340);
      rst_n = 1'b1;
      base = cyc;

      exp_at(0, 3'b111, 8'h00, 4'd0, 1'b0, "rerun_start");
      exp_at(2, 3'b111, 8'h00, 4'd0, 1'b0, "rerun_dark");
      exp_at(22, 3'b101, 8'h00, 4'd1, 1'b0, "rerun_front_clear");
      exp_at(59, 3'b111, 8'h00, 4'd2, 1'b0, "rerun_frame_end");
      exp_at(60, 3'b111, 8'h00, 4'd0, 1'b0, "no_ack_after_reset");
      exp_at(61, 3'b111, 8'h00, 4'd0, 1'b0, "no_ack_late");
      exp_at(62, 3'b110, 8'h00, 4'd0, 1'b0, "rerun_lit");

      goto(70);
      if (q.size() > 0) begin
         n_fail += q.size();
         n_chk += q.size();
         $display("FAIL drain: %0d expectations never sampled, required 0",
                  q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
